// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared defaults and helpers for the multi-channel clock divider
//
// Purpose : default channel count, counter width and reset divide value,
//           plus the width function used for the channel-select port.
// Ports   : none (package).

package clk_div_multi_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 50000;

  // Width of a channel index; a single-channel build still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one programmable divider channel
//
// Purpose : divides clk_in by 2*(active_div+1), producing a 50% duty clock
//           and a one-cycle tick on every toggle. A new divide value is
//           staged in pending_div and only adopted at a terminal count, so
//           the output never sees a shortened or stretched half-period.
// Ports   : clk_in      system clock, rising edge
//           reset       asynchronous, active-high
//           sync        (CLK_DIV_MULTI_PHASE_ALIGN_EN only) phase-align restart
//           en          run enable; low freezes cnt/clk_out/active_div
//           wr_en       write strobe, already decoded for this channel
//           wr_div      new divide value for pending_div
//           clk_out     divided clock
//           tick        one-cycle pulse coincident with each clk_out change
// Macro   : CLK_DIV_MULTI_PHASE_ALIGN_EN adds the sync input.

module clk_div_chan
  import clk_div_multi_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pending_div;
  logic             terminal;
  logic             align;

  // cnt is only ever reloaded to 0 and never passes active_div, so equality
  // is a complete terminal test.
  assign terminal = (cnt == active_div);

`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
  assign align = sync;
`else
  assign align = 1'b0;
`endif

  // Staging register: writable regardless of en, never disturbs the count.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pending_div <= DIV_RST;
    end else if (wr_en) begin
      pending_div <= wr_div;
    end
  end

  // Reloads read the pre-write pending_div, so a write landing on a terminal
  // cycle takes effect only at the following terminal.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      active_div <= DIV_RST;
    end else if (align) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      active_div <= pending_div;
    end else if (en) begin
      if (terminal) begin
        cnt        <= '0;
        clk_out    <= ~clk_out;
        tick       <= 1'b1;
        active_div <= pending_div;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider (top)
//
// Purpose : NUM_CH independent divider channels sharing one write port.
// Ports   : clk_in   system clock, rising edge
//           reset    asynchronous, active-high
//           sync     (CLK_DIV_MULTI_PHASE_ALIGN_EN only) restart all channels in phase
//           en       per-channel run enable
//           wr_en    divide-value write strobe
//           wr_ch    channel addressed by the write
//           wr_div   new divide value
//           clk_out  divided clocks, 50% duty
//           tick     one-cycle pulse on every clk_out toggle
// Macro   : CLK_DIV_MULTI_PHASE_ALIGN_EN adds the sync input.

module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              reset,
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Exact index match: an out-of-range wr_ch selects no channel.
    logic ch_wr;
    assign ch_wr = wr_en && (wr_ch == CH_W'(c));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
`ifdef CLK_DIV_MULTI_PHASE_ALIGN_EN
      .sync    (sync),
`endif
      .en      (en[c]),
      .wr_en   (ch_wr),
      .wr_div  (wr_div),
      .clk_out (clk_out[c]),
      .tick    (tick[c])
    );
  end

endmodule
